// File: rtl/fft_frame_reader_if.sv
// ----------------------------------------------------------------------------
// fft_frame_reader_if
//    Bundles the two buses of the FFT frame reader: the read port of the
//    sample RAM and the valid/ready output stream.
//
//    ram_rd_addr  address presented to the RAM read port
//    ram_rd_data  RAM read data, returned a fixed number of cycles later
//    m_data       stream data
//    m_valid      stream valid
//    m_ready      stream ready from downstream
//    m_last       marks the final sample of a frame
//
//    master : the frame reader (drives the address and the stream)
//    slave  : RAM plus downstream consumer
// ----------------------------------------------------------------------------
interface fft_frame_reader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output ram_rd_addr,
      input  ram_rd_data,
      output m_data,
      output m_valid,
      input  m_ready,
      output m_last
   );

   modport slave (
      input  ram_rd_addr,
      output ram_rd_data,
      input  m_data,
      input  m_valid,
      output m_ready,
      input  m_last
   );
endinterface

// File: rtl/fft_frame_reader.sv
// ----------------------------------------------------------------------------
// fft_frame_reader
//    Read-side sequencer for the FFT sample RAM. A start pulse walks the RAM
//    read port over one frame; returning words pass through a small output
//    FIFO and leave as a valid/ready stream with m_last on the final sample.
//    Reads are only issued when the FIFO is guaranteed to have room for them,
//    so backpressure never loses a RAM word.
//
//    rd_clk      clock
//    rd_rst_n    asynchronous active-low reset
//    start       one-cycle pulse, accepted only when idle
//    frame_last  last address of the frame (length-1), sampled with start
//    busy        high from start acceptance until done
//    done        one-cycle pulse after the last beat is accepted
//    bus         RAM read port and output stream (master modport)
// ----------------------------------------------------------------------------
module fft_frame_reader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 12,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int BIT_REV    = 0
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] frame_last,
   output logic                  busy,
   output logic                  done,
   fft_frame_reader_if.master    bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] last_addr;

   // Stage 0 tracks the address register, stage RD_LATENCY lines up with
   // valid data on ram_rd_data.
   logic [RD_LATENCY:0]   pipe_vld;
   logic [RD_LATENCY:0]   pipe_last;

   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      fifo_count;

   logic [CNT_W-1:0]      inflight;
   logic                  credit_ok;
   logic                  issue;
   logic [ADDR_WIDTH-1:0] issue_idx;
   logic                  issue_last;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  head_last;

   function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
      logic [ADDR_WIDTH-1:0] r;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         r[i] = v[ADDR_WIDTH-1-i];
      end
      return r;
   endfunction

   // Credit check: every read still in the pipe already owns a FIFO slot.
   // fifo_count is taken before this cycle's pop, which keeps it conservative.
   // The first read goes out on the start edge itself, so address 0 is on the
   // RAM port right after start is sampled; the FIFO is empty while idle.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(pipe_vld[i]);
      end
      credit_ok  = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);
      issue      = ((state == ST_IDLE) && start) || ((state == ST_READ) && credit_ok);
      issue_idx  = (state == ST_IDLE) ? '0 : cnt;
      issue_last = (state == ST_IDLE) ? (frame_last == '0) : (cnt == last_addr);
   end

   assign fifo_push   = pipe_vld[RD_LATENCY];
   assign bus.m_valid = (fifo_count != '0);
   assign fifo_pop    = bus.m_valid && bus.m_ready;
   assign head_last   = fifo_last[rd_ptr];
   assign bus.m_data  = bus.m_valid ? fifo_data[rd_ptr] : '0;
   assign bus.m_last  = bus.m_valid && head_last;

   // Frame sequencer. done is raised on the edge that accepts the last beat
   // while the FSM stays in DRAIN for that cycle, so a start coinciding with
   // done is ignored. cnt may wrap after the final issue; by then the FSM has
   // left READ and the value is never used.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         last_addr       <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         bus.ram_rd_addr <= '0;
      end else begin
         done <= 1'b0;
         if (issue) begin
            bus.ram_rd_addr <= (BIT_REV != 0) ? bitrev(issue_idx) : issue_idx;
            cnt             <= issue_idx + ADDR_WIDTH'(1);
         end
         case (state)
            ST_IDLE: begin
               if (start) begin
                  last_addr <= frame_last;
                  busy      <= 1'b1;
                  state     <= (frame_last == '0) ? ST_DRAIN : ST_READ;
               end
            end
            ST_READ: begin
               if (issue && issue_last) begin
                  state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (done) begin
                  state <= ST_IDLE;
               end else if (fifo_pop && head_last) begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read-latency pipe: a valid bit and last tag follow each address until
   // its data appears on ram_rd_data.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         pipe_vld  <= '0;
         pipe_last <= '0;
      end else begin
         pipe_vld  <= {pipe_vld[RD_LATENCY-1:0], issue};
         pipe_last <= {pipe_last[RD_LATENCY-1:0], issue && issue_last};
      end
   end

   // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage; contents are only observed once the count says valid.
   always_ff @(posedge rd_clk) begin
      if (fifo_push) begin
         fifo_data[wr_ptr] <= bus.ram_rd_data;
         fifo_last[wr_ptr] <= pipe_last[RD_LATENCY];
      end
   end

endmodule

// File: tb/tb_fft_frame_reader.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_reader
//    Three reader instances share one clock and reset: linear with one-cycle
//    RAM latency, bit-reversed with one-cycle latency, and linear with
//    two-cycle latency. Each has a RAM model holding RAM[a] = a. Expected
//    beats are queued when a frame is started and popped as the stream
//    delivers them.
// ----------------------------------------------------------------------------
module tb_fft_frame_reader;

   localparam int AW    = 10;
   localparam int DW    = 12;
   localparam int DEPTH = 4;
   localparam int NINST = 3;
   localparam int NVEC  = 7;

   typedef struct {
      int inst;
      int fl;
      int mode;
      int exp_first;
      int exp_last;
      bit overlap;
   } vec_t;

   logic rd_clk   = 1'b0;
   logic rd_rst_n = 1'b0;
   logic [NINST-1:0] start   = '0;
   logic [NINST-1:0] m_ready = '0;
   logic [AW-1:0]    frame_last = '0;

   logic [NINST-1:0]         busy;
   logic [NINST-1:0]         done;
   logic [NINST-1:0]         mon_valid;
   logic [NINST-1:0]         mon_last;
   logic [NINST-1:0]         ovf;
   logic [NINST-1:0][DW-1:0] mon_data;
   logic [NINST-1:0][AW-1:0] mon_addr;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int act, start_cyc, first_v, last_acc, done_at, done_cnt, beats, ovf_cnt;
   logic          stalled;
   logic [DW-1:0] held_data;
   logic          held_last;
   logic [DW:0]   exp_q[$];
   vec_t          vecs[NVEC];

   always #5 rd_clk = ~rd_clk;

   // One reader plus RAM model per configuration.
   for (genvar g = 0; g < NINST; g++) begin : inst
      localparam int LAT = (g == 2) ? 2 : 1;
      localparam int BR  = (g == 1) ? 1 : 0;
      logic [DW-1:0] rp0;
      logic [DW-1:0] rp1;

      fft_frame_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

      fft_frame_reader #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT),
         .FIFO_DEPTH(DEPTH), .BIT_REV(BR)
      ) dut (
         .rd_clk     (rd_clk),
         .rd_rst_n   (rd_rst_n),
         .start      (start[g]),
         .frame_last (frame_last),
         .busy       (busy[g]),
         .done       (done[g]),
         .bus        (bus)
      );

      always_ff @(posedge rd_clk) begin
         rp0 <= DW'(bus.ram_rd_addr);
         rp1 <= rp0;
      end

      assign bus.ram_rd_data = (LAT == 2) ? rp1 : rp0;
      assign bus.m_ready     = m_ready[g];
      assign mon_valid[g]    = bus.m_valid;
      assign mon_last[g]     = bus.m_last;
      assign mon_data[g]     = bus.m_data;
      assign mon_addr[g]     = bus.ram_rd_addr;
      assign ovf[g]          = dut.fifo_push && (int'(dut.fifo_count) == DEPTH);
   end

   function automatic logic [AW-1:0] revBits(input int k);
      logic [AW-1:0] r;
      r = '0;
      for (int b = 0; b < AW; b++) begin
         if (((k >> b) & 1) != 0) r[AW-1-b] = 1'b1;
      end
      return r;
   endfunction

   function automatic int expAddr(input int g, input int k);
      return (g == 1) ? int'(revBits(k)) : k;
   endfunction

   function automatic logic readyFor(input int mode, input int off);
      case (mode)
         0:       return 1'b1;
         1:       return (off % 2) == 0;
         default: return off >= 20;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic resetMeasure();
      first_v  = -1;
      last_acc = -1;
      done_at  = -1;
      done_cnt = 0;
      beats    = 0;
      ovf_cnt  = 0;
      stalled  = 1'b0;
   endtask

   // Advance to the next falling edge, drive inputs for the coming rising
   // edge, and score whatever the active instance shows.
   task automatic stepCycle(input logic rdy, input logic st);
      logic [DW:0] e;
      @(negedge rd_clk);
      cyc++;
      start[act]   = st;
      m_ready[act] = rdy;
      if (stalled) begin
         checkOutput("stall_valid", int'(mon_valid[act]), 1);
         if (mon_valid[act]) begin
            checkOutput("stall_data", int'(mon_data[act]), int'(held_data));
            checkOutput("stall_last", int'(mon_last[act]), int'(held_last));
         end
         stalled = 1'b0;
      end
      if (mon_valid[act]) begin
         if (first_v < 0) first_v = cyc - start_cyc;
         if (rdy) begin
            checkOutput("beat_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checkOutput("beat_data", int'(mon_data[act]), int'(e[DW-1:0]));
               checkOutput("beat_last", int'(mon_last[act]), int'(e[DW]));
            end
            beats++;
            last_acc = cyc - start_cyc;
         end else begin
            stalled   = 1'b1;
            held_data = mon_data[act];
            held_last = mon_last[act];
         end
      end
      if (done[act]) begin
         done_cnt++;
         done_at = cyc - start_cyc;
      end
      if (ovf != '0) ovf_cnt++;
   endtask

   task automatic applyStimulus(input vec_t v);
      int budget;
      int off;
      resetMeasure();
      act        = v.inst;
      frame_last = AW'(v.fl);
      for (int k = 0; k <= v.fl; k++) begin
         exp_q.push_back({(k == v.fl), DW'(expAddr(v.inst, k))});
      end
      start_cyc = cyc + 1;
      stepCycle(readyFor(v.mode, 0), 1'b1);
      budget = 4 * (v.fl + 1) + 80;
      while (done_at < 0 && (cyc - start_cyc) < budget) begin
         stepCycle(readyFor(v.mode, cyc + 1 - start_cyc), 1'b0);
         off = cyc - start_cyc;
         if (off == 1) checkOutput("busy_high", int'(busy[act]), 1);
         if (v.mode == 2 && off == 20) checkOutput("stall_addr", int'(mon_addr[act]), 3);
      end
      checkOutput("done_seen", (done_at >= 0) ? 1 : 0, 1);
      checkOutput("busy_at_done", int'(busy[act]), 0);
      if (v.overlap) start[act] = 1'b1;
      repeat (6) stepCycle(1'b1, 1'b0);
      checkOutput("done_count", done_cnt, 1);
      checkOutput("first_valid", first_v, v.exp_first);
      checkOutput("done_latency", done_at, last_acc + 1);
      if (v.exp_last >= 0) checkOutput("last_accept", last_acc, v.exp_last);
      checkOutput("beats", beats, v.fl + 1);
      checkOutput("queue_left", exp_q.size(), 0);
      checkOutput("overflow", ovf_cnt, 0);
      if (v.overlap) begin
         checkOutput("overlap_busy", int'(busy[act]), 0);
         checkOutput("overlap_addr", int'(mon_addr[act]), expAddr(v.inst, v.fl));
      end
      exp_q.delete();
   endtask

   initial begin
      vec_t tail;
      // inst, frame_last, ready mode, first valid, last accept, overlap
      vecs[0] = '{0, 1023, 0, 3, 1026, 1'b0};
      vecs[1] = '{0, 1023, 1, 3,   -1, 1'b0};
      vecs[2] = '{0, 1023, 2, 3, 1043, 1'b0};
      vecs[3] = '{0,    0, 0, 3,    3, 1'b0};
      vecs[4] = '{1, 1023, 0, 3, 1026, 1'b0};
      vecs[5] = '{2, 1023, 0, 4,   -1, 1'b0};
      vecs[6] = '{0,    2, 1, 3,   -1, 1'b1};
      tail    = '{0,    7, 0, 3,   10, 1'b0};

      act       = 0;
      start_cyc = 0;
      resetMeasure();

      #12;
      for (int g = 0; g < NINST; g++) begin
         checkOutput("rst_busy",  int'(busy[g]),      0);
         checkOutput("rst_done",  int'(done[g]),      0);
         checkOutput("rst_valid", int'(mon_valid[g]), 0);
         checkOutput("rst_data",  int'(mon_data[g]),  0);
         checkOutput("rst_last",  int'(mon_last[g]),  0);
         checkOutput("rst_addr",  int'(mon_addr[g]),  0);
      end
      @(negedge rd_clk);
      rd_rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
      end

      // Abort a frame with reset after 500 beats, then run a clean frame.
      $display("[TB] reset during frame");
      resetMeasure();
      act        = 0;
      frame_last = AW'(1023);
      for (int k = 0; k < 1024; k++) begin
         exp_q.push_back({(k == 1023), DW'(k)});
      end
      start_cyc = cyc + 1;
      stepCycle(1'b1, 1'b1);
      while (beats < 500 && (cyc - start_cyc) < 3000) stepCycle(1'b1, 1'b0);
      checkOutput("abort_beats", beats, 500);
      rd_rst_n = 1'b0;
      #1;
      checkOutput("abort_busy",  int'(busy[0]),      0);
      checkOutput("abort_done",  int'(done[0]),      0);
      checkOutput("abort_valid", int'(mon_valid[0]), 0);
      checkOutput("abort_data",  int'(mon_data[0]),  0);
      checkOutput("abort_last",  int'(mon_last[0]),  0);
      checkOutput("abort_addr",  int'(mon_addr[0]),  0);
      exp_q.delete();
      done_cnt = 0;
      repeat (4) stepCycle(1'b1, 1'b0);
      rd_rst_n = 1'b1;
      repeat (4) stepCycle(1'b1, 1'b0);
      checkOutput("abort_no_done", done_cnt, 0);
      checkOutput("abort_idle_busy", int'(busy[0]), 0);
      applyStimulus(tail);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
